// File: rtl/axi_burst_ram_slave.sv
// AXI-style INCR burst responder backed by a word RAM of 2^ADDR_W 32-bit words.
// Serves one read or write burst at a time, with a sticky flag for wlast mismatches.
module axi_burst_ram_slave #(
  parameter int ADDR_W      = 12,
  parameter int WRITE_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  output logic        wlast_err
);

  typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        beat_cnt;
  logic [3:0]        beat_len;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  logic              write_prio;
  logic [ADDR_W-1:0] ar_idx;
  logic [ADDR_W-1:0] aw_idx;
  logic [ADDR_W-1:0] idx_next;
  logic              ar_hs;
  logic              aw_hs;
  logic              r_hs;
  logic              w_hs;
  logic              b_hs;
  logic              w_final;
  logic              unused_bits;

  assign write_prio = (WRITE_FIRST != 0);
  assign ar_idx     = araddr[ADDR_W+1:2];
  assign aw_idx     = awaddr[ADDR_W+1:2];
  assign idx_next   = idx + IDX_ONE;

  // Only one address channel can be ready while the other is requesting.
  assign arready = (state == IDLE) & rst & ~(write_prio & awvalid);
  assign awready = (state == IDLE) & rst & ~(~write_prio & arvalid);
  assign wready  = (state == WDATA);

  assign ar_hs   = arvalid & arready;
  assign aw_hs   = awvalid & awready;
  assign r_hs    = rvalid & rready;
  assign w_hs    = wvalid & wready;
  assign b_hs    = bvalid & bready;
  assign w_final = (beat_cnt == beat_len);

  assign unused_bits = ^{arsize, awsize, araddr[31:ADDR_W+2], araddr[1:0],
                         awaddr[31:ADDR_W+2], awaddr[1:0]};

  // Burst sequencer: read data is prefetched one cycle ahead so beats stream back-to-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      beat_cnt  <= '0;
      beat_len  <= '0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rdata     <= '0;
      bvalid    <= 1'b0;
      wlast_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            idx      <= aw_idx;
            beat_len <= awlen;
            beat_cnt <= '0;
            state    <= WDATA;
          end else if (ar_hs) begin
            idx      <= ar_idx;
            beat_len <= arlen;
            beat_cnt <= '0;
            rdata    <= mem[ar_idx];
            rvalid   <= 1'b1;
            rlast    <= (arlen == 4'd0);
            state    <= RDATA;
          end
        end
        RDATA: begin
          if (r_hs) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              state  <= IDLE;
            end else begin
              idx      <= idx_next;
              beat_cnt <= beat_cnt + 4'd1;
              rdata    <= mem[idx_next];
              rlast    <= ((beat_cnt + 4'd1) == beat_len);
            end
          end
        end
        WDATA: begin
          if (w_hs) begin
            if (wlast != w_final) begin
              wlast_err <= 1'b1;
            end
            idx      <= idx_next;
            beat_cnt <= beat_cnt + 4'd1;
            if (w_final) begin
              bvalid <= 1'b1;
              state  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (b_hs) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM contents survive reset, so the write port sits outside the reset domain.
  always_ff @(posedge clk) begin
    if (state == WDATA && wvalid) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Directed bench for axi_burst_ram_slave: a 12-bit-address instance for the main
// scenarios and a 4-bit-address instance sharing the same inputs for the wrap case.
module tb_axi_burst_ram_slave;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        bready;

  logic        arready, rlast, rvalid, awready, wready, bvalid, wlast_err;
  logic [31:0] rdata;
  logic        arready4, rlast4, rvalid4, awready4, wready4, bvalid4, wlast_err4;
  logic [31:0] rdata4;

  int vectors;
  int miscompares;

  logic [31:0] wbuf     [16];
  logic        s_rvalid [16];
  logic        s_rlast  [16];
  logic [31:0] s_rdata  [16];
  logic        s_rvalid4[16];
  logic        s_rlast4 [16];
  logic [31:0] s_rdata4 [16];

  axi_burst_ram_slave #(.ADDR_W(12), .WRITE_FIRST(1)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .wlast_err(wlast_err)
  );

  axi_burst_ram_slave #(.ADDR_W(4), .WRITE_FIRST(1)) dut4 (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready4),
    .rdata(rdata4), .rlast(rlast4), .rvalid(rvalid4), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready4),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready4),
    .bvalid(bvalid4), .bready(bready), .wlast_err(wlast_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_aw(input logic [31:0] a, input logic [3:0] l, output bit ok);
    ok = 1'b0;
    awaddr = a; awlen = l; awvalid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [3:0] l, output bit ok);
    ok = 1'b0;
    araddr = a; arlen = l; arvalid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
  endtask

  task automatic do_w(input int n, input int last_pos, input logic [3:0] strb, output bit ok);
    bit got;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wlast = (i == last_pos);
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = wready;
        @(posedge clk); #1;
      end
      if (!got) ok = 1'b0;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bvalid;
      @(posedge clk); #1;
    end
    bready = 1'b0;
    if (!got) ok = 1'b0;
  endtask

  // Index 0 of the sample arrays is the cycle right after the AR handshake.
  task automatic sample_read(input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) begin
      rready = pat[i];
      @(negedge clk);
      s_rvalid[i]  = rvalid;  s_rdata[i]  = rdata;  s_rlast[i]  = rlast;
      s_rvalid4[i] = rvalid4; s_rdata4[i] = rdata4; s_rlast4[i] = rlast4;
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    araddr = '0; arlen = '0; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
    awaddr = '0; awlen = '0; awsize = 3'd2; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (arready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_arready got=%0b exp=0", arready); end
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid got=%0b exp=0", rvalid); end
    vectors++; if (rlast !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rlast got=%0b exp=0", rlast); end
    vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bvalid got=%0b exp=0", bvalid); end
    vectors++; if (wlast_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wlast_err got=%0b exp=0", wlast_err); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata got=%08h exp=00000000", rdata); end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_burst_rw();
    bit ok;
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + i;
    do_aw(32'h100, 4'd7, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_aw_timeout got=%0b exp=1", ok); end
    do_w(8, 7, 4'hF, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_w_timeout got=%0b exp=1", ok); end
    vectors++; if (wlast_err !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_wlast_err got=%0b exp=0", wlast_err); end
    do_ar(32'h100, 4'd7, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_ar_timeout got=%0b exp=1", ok); end
    sample_read(10, 16'hFFFF);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (s_rvalid[i] !== (i < 8)) begin
        miscompares++; $display("[TB] FAIL burst_rvalid[%0d] got=%0b exp=%0b", i, s_rvalid[i], (i < 8));
      end
      if (i < 8) begin
        vectors++;
        if (s_rdata[i] !== 32'hA0 + i) begin
          miscompares++; $display("[TB] FAIL burst_rdata[%0d] got=%08h exp=%08h", i, s_rdata[i], 32'hA0 + i);
        end
        vectors++;
        if (s_rlast[i] !== (i == 7)) begin
          miscompares++; $display("[TB] FAIL burst_rlast[%0d] got=%0b exp=%0b", i, s_rlast[i], (i == 7));
        end
      end
    end
  endtask

  task automatic test_byte_strobe();
    bit ok;
    wbuf[0] = 32'h11223344;
    do_aw(32'h40, 4'd0, ok);
    do_w(1, 0, 4'hF, ok);
    wbuf[0] = 32'hAABBCCDD;
    do_aw(32'h40, 4'd0, ok);
    do_w(1, 0, 4'h5, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL strobe_w_timeout got=%0b exp=1", ok); end
    do_ar(32'h40, 4'd0, ok);
    sample_read(2, 16'hFFFF);
    vectors++; if (s_rdata[0] !== 32'h11BB33DD) begin miscompares++; $display("[TB] FAIL strobe_rdata got=%08h exp=11bb33dd", s_rdata[0]); end
    vectors++; if (s_rlast[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL strobe_rlast got=%0b exp=1", s_rlast[0]); end
    vectors++; if (s_rvalid[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL strobe_rvalid_end got=%0b exp=0", s_rvalid[1]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [15:0] pat;
    int beat;
    int hs;
    pat = 16'h9999;
    do_ar(32'h100, 4'd3, ok);
    sample_read(12, pat);
    beat = 0;
    hs = 0;
    for (int i = 0; i < 12; i++) begin
      if (s_rvalid[i] === 1'b1 && pat[i]) hs++;
      vectors++;
      if (beat < 4) begin
        if (s_rvalid[i] !== 1'b1 || s_rdata[i] !== 32'hA0 + beat || s_rlast[i] !== (beat == 3)) begin
          miscompares++;
          $display("[TB] FAIL bp_beat[%0d] got v=%0b d=%08h l=%0b exp v=1 d=%08h l=%0b",
                   i, s_rvalid[i], s_rdata[i], s_rlast[i], 32'hA0 + beat, (beat == 3));
        end
        if (pat[i]) beat++;
      end else begin
        if (s_rvalid[i] !== 1'b0) begin
          miscompares++; $display("[TB] FAIL bp_idle[%0d] got rvalid=%0b exp=0", i, s_rvalid[i]);
        end
      end
    end
    vectors++; if (hs != 4) begin miscompares++; $display("[TB] FAIL bp_handshakes got=%0d exp=4", hs); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    arvalid = 1'b1; araddr = 32'h100; arlen = 4'd0;
    awvalid = 1'b1; awaddr = 32'h180; awlen = 4'd0;
    @(negedge clk);
    vectors++; if (awready !== 1'b1 || awready4 !== 1'b1) begin miscompares++; $display("[TB] FAIL arb_awready got=%0b/%0b exp=1", awready, awready4); end
    vectors++; if (arready !== 1'b0 || arready4 !== 1'b0) begin miscompares++; $display("[TB] FAIL arb_arready got=%0b/%0b exp=0", arready, arready4); end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h5555_0055; wstrb = 4'hF; wlast = 1'b1;
    @(negedge clk);
    vectors++; if (wready !== 1'b1 || arready !== 1'b0) begin miscompares++; $display("[TB] FAIL arb_wdata got wready=%0b arready=%0b exp 1/0", wready, arready); end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge clk);
    vectors++; if (bvalid !== 1'b1 || arready !== 1'b0) begin miscompares++; $display("[TB] FAIL arb_bresp got bvalid=%0b arready=%0b exp 1/0", bvalid, arready); end
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    vectors++; if (bvalid !== 1'b0 || arready !== 1'b1) begin miscompares++; $display("[TB] FAIL arb_ar_after_b got bvalid=%0b arready=%0b exp 0/1", bvalid, arready); end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    vectors++; if (rvalid !== 1'b1 || rdata !== 32'hA0 || rlast !== 1'b1) begin miscompares++; $display("[TB] FAIL arb_read got v=%0b d=%08h l=%0b exp 1/000000a0/1", rvalid, rdata, rlast); end
    @(posedge clk); #1;
    rready = 1'b0;
    do_ar(32'h180, 4'd0, ok);
    sample_read(1, 16'hFFFF);
    vectors++; if (s_rdata[0] !== 32'h5555_0055) begin miscompares++; $display("[TB] FAIL arb_wr_data got=%08h exp=55550055", s_rdata[0]); end
  endtask

  task automatic test_wrap_error();
    bit ok;
    vectors++; if (wlast_err4 !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_err_pre got=%0b exp=0", wlast_err4); end
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + i;
    do_aw(32'h38, 4'd3, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_aw_timeout got=%0b exp=1", ok); end
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = 4'hF; wlast = (i == 1);
      @(negedge clk);
      vectors++;
      if (wready4 !== 1'b1 || bvalid4 !== 1'b0) begin
        miscompares++; $display("[TB] FAIL wrap_beat[%0d] got wready=%0b bvalid=%0b exp 1/0", i, wready4, bvalid4);
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    vectors++; if (bvalid4 !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_bvalid got=%0b exp=1", bvalid4); end
    vectors++; if (wlast_err4 !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_wlast_err got=%0b exp=1", wlast_err4); end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    do_ar(32'h38, 4'd3, ok);
    sample_read(5, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (s_rvalid4[i] !== 1'b1 || s_rdata4[i] !== 32'hC0DE0000 + i || s_rlast4[i] !== (i == 3)) begin
        miscompares++;
        $display("[TB] FAIL wrap_read[%0d] got v=%0b d=%08h l=%0b exp 1/%08h/%0b",
                 i, s_rvalid4[i], s_rdata4[i], s_rlast4[i], 32'hC0DE0000 + i, (i == 3));
      end
    end
    do_ar(32'h0, 4'd1, ok);
    sample_read(2, 16'hFFFF);
    vectors++; if (s_rdata4[0] !== 32'hC0DE0002) begin miscompares++; $display("[TB] FAIL wrap_word0 got=%08h exp=c0de0002", s_rdata4[0]); end
    vectors++; if (s_rdata4[1] !== 32'hC0DE0003) begin miscompares++; $display("[TB] FAIL wrap_word1 got=%08h exp=c0de0003", s_rdata4[1]); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_ar(32'h100, 4'd7, ok);
    sample_read(2, 16'hFFFF);
    vectors++; if (s_rdata[1] !== 32'hA1) begin miscompares++; $display("[TB] FAIL rstmid_beat2 got=%08h exp=000000a1", s_rdata[1]); end
    arvalid = 1'b1;
    rst = 1'b0;
    #1;
    vectors++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_rvalid got v=%0b l=%0b exp 0/0", rvalid, rlast); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rstmid_rdata got=%08h exp=00000000", rdata); end
    vectors++; if (arready !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_arready got=%0b exp=0", arready); end
    vectors++; if (wlast_err !== 1'b0 || wlast_err4 !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_wlast_err got=%0b/%0b exp=0", wlast_err, wlast_err4); end
    @(posedge clk); #1;
    rst = 1'b1;
    arvalid = 1'b0;
    do_ar(32'h104, 4'd1, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_ar_timeout got=%0b exp=1", ok); end
    sample_read(3, 16'hFFFF);
    vectors++; if (s_rvalid[0] !== 1'b1 || s_rdata[0] !== 32'hA1 || s_rlast[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_read0 got v=%0b d=%08h l=%0b exp 1/000000a1/0", s_rvalid[0], s_rdata[0], s_rlast[0]); end
    vectors++; if (s_rvalid[1] !== 1'b1 || s_rdata[1] !== 32'hA2 || s_rlast[1] !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_read1 got v=%0b d=%08h l=%0b exp 1/000000a2/1", s_rvalid[1], s_rdata[1], s_rlast[1]); end
    vectors++; if (s_rvalid[2] !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_read_end got=%0b exp=0", s_rvalid[2]); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_burst_rw();
    test_byte_strobe();
    test_backpressure();
    test_back_to_back();
    test_wrap_error();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_burst_ram_slave.md
Name: axi_burst_ram_slave

Overview:
- AXI-style burst responder backed by an internal word RAM; the memory end of the data-cache burst master.
- Accepts INCR bursts of 1–16 beats on the read and write channels.
- Streams read data with rlast, commits write beats under wstrb, and returns a single write response.
- One transaction at a time. Used as the simulation/FPGA memory behind the dcache refill and writeback paths.

Parameters:
- ADDR_W, 12, word-address width; the RAM holds 2^ADDR_W 32-bit words.
- WRITE_FIRST, 1, arbitration when arvalid and awvalid are both high in IDLE: 1 selects write, 0 selects read.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- araddr  in  32  read burst byte address.
- arlen  in  4  read beats minus 1.
- arsize  in  3  transfer size; ignored, every beat is a full word.
- arvalid  in  1  read address valid.
- arready  out  1  read address accepted.
- rdata  out  32  read beat data.
- rlast  out  1  final read beat.
- rvalid  out  1  read beat valid.
- rready  in  1  master accepts read beat.
- awaddr  in  32  write burst byte address.
- awlen  in  4  write beats minus 1.
- awsize  in  3  ignored.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  32  write beat data.
- wstrb  in  4  byte enables; bit i selects wdata[8i+7:8i].
- wlast  in  1  master's last-beat marker.
- wvalid  in  1  write beat valid.
- wready  out  1  slave accepts write beat.
- bvalid  out  1  write response valid.
- bready  in  1  master accepts response.
- wlast_err  out  1  sticky flag: wlast disagreed with the beat count.

Behaviour:
- States: IDLE, RDATA, WDATA, WRESP.
- Reset (rst low, asynchronous):
  - State goes to IDLE; beat counters clear.
  - rvalid, rlast, bvalid, wlast_err go to 0; rdata goes to 0.
  - arready and awready are 0 while rst is low.
  - RAM contents are not reset.
- Reset mid-burst abandons the transaction. The next burst starts cleanly from IDLE.
- Ready signals:
  - arready = IDLE & rst & !(WRITE_FIRST & awvalid).
  - awready = IDLE & rst & !(!WRITE_FIRST & arvalid).
  - At most one address handshake per cycle.
- Addressing:
  - Word index = addr[ADDR_W+1:2].
  - addr[1:0] and bits above ADDR_W+1 are ignored.
  - Each beat increments the word index by 1, modulo 2^ADDR_W. A burst past the top wraps to word 0.
- Read burst:
  - AR handshake at cycle T: latch index and arlen, clear beat counter, go to RDATA.
  - rvalid=1 from T+1, with rdata = RAM[index] registered.
  - On each rvalid&rready: advance the index. The next beat's data is valid in the following cycle, so beats run back-to-back with no bubble while rready stays high.
  - rlast=1 exactly when beat counter == latched arlen.
  - With rready low, rdata, rlast and rvalid hold stable.
  - Handshake on the rlast beat: rvalid drops next cycle and state returns to IDLE.
  - arlen=0 gives a single beat with rlast=1.
- Write burst:
  - AW handshake: latch index and awlen, go to WDATA. wready=1 throughout WDATA.
  - Each wvalid&wready writes RAM[index] byte-wise under wstrb, then increments index and counter.
  - The beat with counter == awlen is the final beat regardless of wlast, and moves state to WRESP.
  - If wlast differs from (counter == awlen) on any accepted beat, wlast_err is set to 1 and stays set until reset.
  - WRESP: bvalid=1 until bready; the handshake returns state to IDLE.
- The RAM has one access per cycle: a write beat and a read fetch never coincide because bursts are serialised.
- Write-then-read to the same address returns the new data; no forwarding is needed since the read starts after WRESP.
- A new address is accepted only in IDLE, so the earliest next handshake is the cycle after the B or final-R handshake.

Test Plan:
- Write burst at awaddr=0x100, awlen=7, wdata=0xA0..0xA7, wstrb=0xF, then read at araddr=0x100, arlen=7, rready=1 -> 8 consecutive rvalid beats 0xA0..0xA7, rlast only on the 8th, first rvalid one cycle after AR handshake.
- Byte strobes: write 0x11223344 with wstrb=0xF to 0x40, then single write 0xAABBCCDD with wstrb=0x5 -> read returns 0x11BB33DD.
- Backpressure: 4-beat read with rready toggling 1,0,0,1,... -> rdata/rlast stable while rready=0, exactly 4 handshakes, data order preserved.
- Simultaneous arvalid and awvalid in IDLE with WRITE_FIRST=1 -> awready=1, arready=0; AR accepted the cycle after the B handshake.
- Wrap and error: ADDR_W=4, write awaddr=0x38, awlen=3 with wlast on beat 2 -> words 14,15,0,1 written, wlast_err=1, bvalid after beat 4.
- Reset mid read burst (rst low for 1 cycle after beat 2 of 8) -> rvalid=0 immediately, IDLE after release, next 2-beat read completes correctly, and previously written RAM data is intact.
